// File: rtl/fb_ddr_wrbuf.sv
// Write buffer: queues 32-bit pixel writes and issues 64-bit lane-enabled DDRAM writes honouring BUSY.
// Optional tail merging of complementary half-word writes is enabled by defining JTFRAME_FBWR_MERGE_EN.
module fb_ddr_wrbuf #(
  parameter int AW    = 29,
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          clk_video,
  input  logic          rst,
  input  logic          in_we,
  input  logic [AW:0]   in_addr,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic [LW-1:0] level,
  output logic [7:0]    drop_cnt,
  input  logic          clr_cnt,
  input  logic          DDRAM_BUSY,
  output logic [AW-1:0] DDRAM_ADDR,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic          DDRAM_RD
);

  localparam int PW = LW - 1;

  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  state_t        state_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          nonempty_q;
  logic [7:0]    drop_q;
  logic [AW-1:0] out_addr_q;
  logic [63:0]   out_data_q;
  logic [7:0]    out_be_q;
  logic          out_we_q;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [63:0]   data_mem_q [DEPTH];
  logic [7:0]    be_mem_q   [DEPTH];

  logic [AW-1:0] new_addr;
  logic [63:0]   new_data;
  logic [7:0]    new_be;
  logic          full, nonzero, pop, push, merge, drop;

  assign new_addr = in_addr[AW:1];
  assign new_data = {in_data, in_data};
  assign new_be   = in_addr[0] ? 8'hF0 : 8'h0F;
  assign nonzero  = (level_q != '0);
  assign full     = (level_q == LW'(DEPTH));

  // IDLE pops on the registered non-empty flag, giving a two-edge in_we-to-WE latency.
  assign pop = nonzero &&
               (((state_q == ST_IDLE) && nonempty_q) ||
                ((state_q == ST_WRITE) && !DDRAM_BUSY));

`ifdef JTFRAME_FBWR_MERGE_EN
  logic [PW-1:0] tail_ptr;
  logic [63:0]   merge_data;

  always_comb begin
    tail_ptr   = wr_ptr_q - PW'(1);
    merge      = in_we && nonzero && !(pop && (level_q == LW'(1))) &&
                 (addr_mem_q[tail_ptr] == new_addr) &&
                 ((be_mem_q[tail_ptr] & new_be) == '0);
    merge_data = data_mem_q[tail_ptr];
    for (int unsigned i = 0; i < 8; i++) begin
      if (new_be[i]) merge_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end
`else
  assign merge = 1'b0;
`endif

  assign push = in_we && !merge && (!full || pop);
  assign drop = in_we && !merge && !push;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_video) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= new_addr;
      data_mem_q[wr_ptr_q] <= new_data;
      be_mem_q[wr_ptr_q]   <= new_be;
    end
`ifdef JTFRAME_FBWR_MERGE_EN
    if (merge) begin
      data_mem_q[tail_ptr] <= merge_data;
      be_mem_q[tail_ptr]   <= be_mem_q[tail_ptr] | new_be;
    end
`endif
  end

  always_ff @(posedge clk_video) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      nonempty_q <= 1'b0;
      drop_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_be_q   <= '0;
      out_we_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q    <= level_d;
      nonempty_q <= nonzero;

      if (clr_cnt)                      drop_q <= '0;
      else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      if (pop) begin
        out_addr_q <= addr_mem_q[rd_ptr_q];
        out_data_q <= data_mem_q[rd_ptr_q];
        out_be_q   <= be_mem_q[rd_ptr_q];
        out_we_q   <= 1'b1;
        state_q    <= ST_WRITE;
      end else if ((state_q == ST_WRITE) && !DDRAM_BUSY) begin
        out_we_q   <= 1'b0;
        state_q    <= ST_IDLE;
      end
    end
  end

  assign in_ready       = !full;
  assign level          = level_q;
  assign drop_cnt       = drop_q;
  assign DDRAM_ADDR     = out_addr_q;
  assign DDRAM_DIN      = out_data_q;
  assign DDRAM_BE       = out_be_q;
  assign DDRAM_WE       = out_we_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_fb_ddr_wrbuf.sv
// Self-checking bench for fb_ddr_wrbuf: expected DDRAM write stream built from accepted pixel writes.
module tb_fb_ddr_wrbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_we = 1'b0;
  logic [29:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;
  logic        clr_cnt = 1'b0;
  logic        busy = 1'b0;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  b;
  } wr_t;

  wr_t exp_q[$];

  fb_ddr_wrbuf #(.AW(29), .DEPTH(16), .LW(5)) dut (
    .clk_video(clk), .rst(rst), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .level(level), .drop_cnt(drop_cnt), .clr_cnt(clr_cnt),
    .DDRAM_BUSY(busy), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_WE(DDRAM_WE), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD)
  );

  always #5 clk = ~clk;

  function automatic wr_t mk(input logic [29:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a[29:1];
    w.d = {d, d};
    w.b = a[0] ? 8'hF0 : 8'h0F;
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: every completed write must match the next expected one; stalled writes must hold.
  logic hold_v = 1'b0;
  wr_t  hold;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if (!DDRAM_WE || DDRAM_ADDR !== hold.a || DDRAM_DIN !== hold.d || DDRAM_BE !== hold.b) begin
          bad++;
          $display("FAIL stall_hold got we=%b a=%h d=%h be=%h exp a=%h d=%h be=%h",
                   DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, hold.a, hold.d, hold.b);
        end
      end
      hold_v = DDRAM_WE && busy;
      hold.a = DDRAM_ADDR; hold.d = DDRAM_DIN; hold.b = DDRAM_BE;
      if (DDRAM_WE && !busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got a=%h d=%h be=%h exp none", DDRAM_ADDR, DDRAM_DIN, DDRAM_BE);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (DDRAM_ADDR !== e.a || DDRAM_DIN !== e.d || DDRAM_BE !== e.b) begin
            bad++;
            $display("FAIL write_data got a=%h d=%h be=%h exp a=%h d=%h be=%h",
                     DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, e.a, e.d, e.b);
          end
        end
      end
    end
  end

  task automatic drain;
    int unsigned n = 0;
    busy = 1'b0;
    while ((exp_q.size() != 0 || level != 0 || DDRAM_WE) && n < 500) begin
      tick;
      n++;
    end
    total++;
    if (exp_q.size() != 0 || level != 0 || DDRAM_WE) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d level=%0d exp pending=0 level=0", exp_q.size(), level);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++;
    if (DDRAM_WE !== 1'b0 || DDRAM_ADDR !== '0 || DDRAM_DIN !== '0 || DDRAM_BE !== '0) begin
      bad++;
      $display("FAIL reset_bus got we=%b a=%h d=%h be=%h exp all 0", DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE);
    end
    total++;
    if (level !== 5'd0 || in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_status got level=%0d ready=%b drop=%0d exp 0 1 0", level, in_ready, drop_cnt);
    end
    total++;
    if (DDRAM_BURSTCNT !== 8'd1 || DDRAM_RD !== 1'b0) begin
      bad++;
      $display("FAIL constants got burst=%0d rd=%b exp 1 0", DDRAM_BURSTCNT, DDRAM_RD);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    busy = 1'b0;
    in_we = 1'b1; in_addr = 30'h13; in_data = 32'h00123456;
    exp_q.push_back(mk(in_addr, in_data));
    tick;
    in_we = 1'b0;
    total++;
    if (level !== 5'd1 || DDRAM_WE !== 1'b0) begin
      bad++;
      $display("FAIL single_edge0 got level=%0d we=%b exp 1 0", level, DDRAM_WE);
    end
    tick;
    total++;
    if (DDRAM_WE !== 1'b0) begin
      bad++;
      $display("FAIL single_edge1 got we=%b exp 0", DDRAM_WE);
    end
    tick;
    total++;
    if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'h9 || DDRAM_BE !== 8'hF0 ||
        DDRAM_DIN !== 64'h0012345600123456) begin
      bad++;
      $display("FAIL single_edge2 got we=%b a=%h be=%h d=%h exp 1 9 f0 0012345600123456",
               DDRAM_WE, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
    end
    tick;
    total++;
    if (DDRAM_WE !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL single_after got we=%b level=%0d exp 0 0", DDRAM_WE, level);
    end
  endtask

  task automatic test_busy_stall;
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_we = 1'b1; in_addr = 30'(2 * i); in_data = $urandom;
      exp_q.push_back(mk(in_addr, in_data));
      tick;
    end
    in_we = 1'b0;
    total++;
    if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'd0 || level !== 5'd2) begin
      bad++;
      $display("FAIL stall_start got we=%b a=%h level=%0d exp 1 0 2", DDRAM_WE, DDRAM_ADDR, level);
    end
    repeat (10) tick;
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'(i)) begin
        bad++;
        $display("FAIL back_to_back[%0d] got we=%b a=%h exp we=1 a=%h", i, DDRAM_WE, DDRAM_ADDR, i);
      end
      tick;
    end
    total++;
    if (DDRAM_WE !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL stall_end got we=%b level=%0d exp 0 0", DDRAM_WE, level);
    end
  endtask

  task automatic test_overflow;
    busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_we = 1'b1; in_addr = 30'(((32'h100 + k) << 1) | (k & 1)); in_data = $urandom;
      if (k < 17) exp_q.push_back(mk(in_addr, in_data));
      tick;
    end
    in_we = 1'b0;
    total++;
    if (level !== 5'd16 || in_ready !== 1'b0 || drop_cnt !== 8'd3) begin
      bad++;
      $display("FAIL overflow got level=%0d ready=%b drop=%0d exp 16 0 3", level, in_ready, drop_cnt);
    end
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    total++;
    if (drop_cnt !== 8'd0 || level !== 5'd16) begin
      bad++;
      $display("FAIL overflow_clr got drop=%0d level=%0d exp 0 16", drop_cnt, level);
    end
    drain;
  endtask

  task automatic test_saturation;
    busy = 1'b1;
    for (int k = 0; k < 320; k++) begin
      in_we = 1'b1; in_addr = 30'((32'h200 + k) << 1); in_data = $urandom;
      if (k < 17) exp_q.push_back(mk(in_addr, in_data));
      tick;
    end
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL saturate got drop=%0d exp 255", drop_cnt);
    end
    in_addr = 30'h7FFE; clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_priority got drop=%0d exp 0", drop_cnt);
    end
    in_addr = 30'h7FFC;
    tick;
    in_we = 1'b0;
    total++;
    if (drop_cnt !== 8'd1) begin
      bad++;
      $display("FAIL drop_after_clr got drop=%0d exp 1", drop_cnt);
    end
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    drain;
  endtask

  task automatic test_merge;
    logic [31:0] d6, d7;
    wr_t m;
    busy = 1'b1;
    in_we = 1'b1; in_addr = 30'h40; in_data = $urandom;
    exp_q.push_back(mk(in_addr, in_data));
    tick;
    in_we = 1'b0;
    tick; tick;
    total++;
    if (DDRAM_WE !== 1'b1) begin
      bad++;
      $display("FAIL merge_setup got we=%b exp 1", DDRAM_WE);
    end
    d6 = $urandom; d7 = $urandom;
    in_we = 1'b1; in_addr = 30'd6; in_data = d6;
    tick;
    in_addr = 30'd7; in_data = d7;
    tick;
    in_we = 1'b0;
`ifdef JTFRAME_FBWR_MERGE_EN
    m.a = 29'd3; m.d = {d7, d6}; m.b = 8'hFF;
    exp_q.push_back(m);
    total++;
    if (level !== 5'd1) begin
      bad++;
      $display("FAIL merge_level got level=%0d exp 1", level);
    end
`else
    m = mk(30'd6, d6);
    exp_q.push_back(m);
    exp_q.push_back(mk(30'd7, d7));
    total++;
    if (level !== 5'd2) begin
      bad++;
      $display("FAIL merge_level got level=%0d exp 2", level);
    end
`endif
    drain;
  endtask

  task automatic test_random;
    logic [29:0] a, last;
    logic        we;
    last = '1;
    for (int c = 0; c < 400; c++) begin
      busy = ($urandom_range(0, 2) == 0);
      we = in_ready && ($urandom_range(0, 1) == 1);
      do a = 30'($urandom); while (a[29:1] == last[29:1]);
      in_we = we; in_addr = a; in_data = $urandom;
      if (we) begin
        exp_q.push_back(mk(a, in_data));
        last = a;
      end
      tick;
    end
    in_we = 1'b0;
    drain;
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL random_drops got drop=%0d exp 0", drop_cnt);
    end
  endtask

  task automatic test_reset_mid;
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_we = 1'b1; in_addr = 30'(32'h900 + 2 * i); in_data = $urandom;
      tick;
    end
    in_we = 1'b0;
    total++;
    if (DDRAM_WE !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_setup got we=%b exp 1", DDRAM_WE);
    end
    rst = 1'b1;
    tick;
    total++;
    if (DDRAM_WE !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid got we=%b level=%0d ready=%b exp 0 0 1", DDRAM_WE, level, in_ready);
    end
    rst = 1'b0;
    busy = 1'b0;
    exp_q.delete();
    repeat (20) tick;
    total++;
    if (DDRAM_WE !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL rstmid_after got we=%b level=%0d exp 0 0", DDRAM_WE, level);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_busy_stall;
    test_overflow;
    test_saturation;
    test_merge;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_ddr_wrbuf.md
Name: fb_ddr_wrbuf

Overview:
- Write buffer between the rotation address/pixel generator and the DDRAM Avalon-MM write port.
- The rotation stage issues single 32-bit pixel writes on CE_PIXEL regardless of DDRAM_BUSY. This block queues them, widens them to 64-bit lane-enabled writes, and issues them to DDRAM with full BUSY compliance.
- It counts any writes lost to overflow.

Parameters:
- AW, 29: DDRAM 64-bit word address width.
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- LW, 5: level width, log2(DEPTH)+1.

Ports:
- clk_video  in  1  video/DDRAM clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_we  in  1  one-cycle pixel write strobe.
- in_addr  in  AW+1  32-bit word address; bit 0 selects the upper/lower half of the 64-bit DDRAM word.
- in_data  in  32  pixel word, {B,G,R} in the low 24 bits.
- in_ready  out  1  FIFO not full (advisory; the producer may ignore it).
- level  out  LW  FIFO occupancy, 0..DEPTH.
- drop_cnt  out  8  saturating count of discarded writes.
- clr_cnt  in  1  synchronous clear of drop_cnt.
- DDRAM_BUSY  in  1  Avalon waitrequest.
- DDRAM_ADDR  out  AW  64-bit word address.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write request.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_RD  out  1  constant 0.

Behaviour:
- Clocking and reset: one clock (clk_video); synchronous active-high reset (rst), sampled on the clk_video rising edge.
- Reset values:
  - FIFO pointers, level, drop_cnt = 0.
  - DDRAM_WE = 0; DDRAM_ADDR/DIN/BE = 0.
  - in_ready = 1.
- Reset mid-transaction: the in-flight write is abandoned. DDRAM_WE is 0 from the first edge with rst high. Queued entries are discarded.
- Entry formation on accepted in_we:
  - addr = in_addr[AW:1].
  - data = {in_data, in_data}.
  - be = in_addr[0] ? 8'hF0 : 8'h0F.
- Push rules:
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise dropped; drop_cnt increments, saturating at 255.
  - clr_cnt has priority over an increment in the same cycle.
- Output FSM:
  - IDLE (DDRAM_WE=0): if FIFO non-empty, pop the head into the output register and go to WRITE.
  - WRITE (DDRAM_WE=1): ADDR/DIN/BE held stable while DDRAM_BUSY=1.
    - On a cycle with DDRAM_BUSY=0 the write completes.
    - If FIFO non-empty: pop the next entry the same cycle and stay in WRITE (back-to-back, no bubble).
    - Otherwise return to IDLE.
- Latency: into an empty FIFO in IDLE, in_we sampled at edge N gives DDRAM_WE=1 after edge N+2.
- level counts FIFO entries only, not the output register:
  - push alone: +1; pop alone: −1; push and pop together: unchanged.
- in_ready = (level != DEPTH).
- Order: DDRAM writes issue in acceptance order; no reordering.
- Address arithmetic: no wrap handling. in_addr is used modulo 2^(AW+1).

Optional Feature:
- Macro: JTFRAME_FBWR_MERGE_EN.
- Defined: an in_we merges into the FIFO tail entry instead of pushing when all of the following hold:
  - the FIFO is non-empty;
  - the tail is not being popped that cycle;
  - tail.addr == in_addr[AW:1];
  - tail.be & new_be == 0.
- Merge result:
  - be = tail.be | new_be;
  - data lanes selected by new_be are replaced with in_data.
  - A merge never drops, even when full, and does not change level.
- Not defined: every accepted in_we produces exactly one DDRAM write with BE 8'h0F or 8'hF0.

Test Plan:
- Reset, single write: in_we, in_addr=0x000013, in_data=0x00123456, BUSY=0 → two edges later: DDRAM_WE=1 for 1 cycle, ADDR=0x000009, BE=F0, DIN=0x0012345600123456; level returns to 0.
- BUSY stall: 3 writes to addrs 0,2,4, BUSY=1 for 10 cycles → ADDR/DIN/BE stable throughout; then 3 back-to-back WE cycles in order with addrs 0,1,2; no gaps.
- Overflow: BUSY=1, 20 writes with DEPTH=16 and merge disabled → level=16, in_ready=0, drop_cnt=3 (1 in the output register + 16 queued); clr_cnt → 0.
- Saturation: 300 dropped writes → drop_cnt=255.
- Merge (JTFRAME_FBWR_MERGE_EN): BUSY=1, writes to in_addr 6 then 7 → level=1; after BUSY drops, one DDRAM write with ADDR=3, BE=FF. Without the macro: two writes, BE 0F then F0.
- Reset mid-write: WE=1 with BUSY=1, assert rst → DDRAM_WE=0 next edge, level=0, and no further writes after release.
